// File: rtl/putc_uart_tx.sv
// Character FIFO feeding an 8N1 UART serializer; tx idles high.
// Optional PUTC_UART_TX_CRLF_EN: a popped 0x0A is sent as 0x0D then 0x0A.
//   state | meaning
//   IDLE  | line high, waiting for a FIFO entry
//   START | start bit (tx=0)
//   DATA  | 8 data bits, LSB first
//   STOP  | stop bit (tx=1), may chain straight into the next START
module putc_uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     putc,
    input  logic [7:0]               putc_char,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     busy,
    output logic                     tx
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   LEVEL_MAX   = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            lf_pending;
    logic            baud_done;
    logic            pop;
    logic            push;
    logic            fifo_empty;
    logic            is_lf;
    logic [7:0]      head;

    assign head       = mem[rd_ptr];
    assign fifo_empty = (level == '0);
    assign full       = (level == LEVEL_MAX);
    assign baud_done  = (baud_cnt == '0);
    assign busy       = !fifo_empty || (state != IDLE);

`ifdef PUTC_UART_TX_CRLF_EN
    assign is_lf = (head == 8'h0A);
`else
    assign is_lf = 1'b0;
`endif

    // The LF half of a CR/LF pair comes from lf_pending, not the FIFO.
    assign pop  = !fifo_empty &&
                  ((state == IDLE) || (state == STOP && baud_done && !lf_pending));
    assign push = putc && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
            if (putc && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= putc_char;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            lf_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg      <= is_lf ? 8'h0D : head;
                        lf_pending <= is_lf;
                        baud_cnt   <= BAUD_RELOAD;
                        tx         <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= BAUD_RELOAD;
                        bit_cnt  <= '0;
                        tx       <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        if (lf_pending) begin
                            shreg      <= 8'h0A;
                            lf_pending <= 1'b0;
                            baud_cnt   <= BAUD_RELOAD;
                            tx         <= 1'b0;
                            state      <= START;
                        end else if (pop) begin
                            shreg      <= is_lf ? 8'h0D : head;
                            lf_pending <= is_lf;
                            baud_cnt   <= BAUD_RELOAD;
                            tx         <= 1'b0;
                            state      <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_putc_uart_tx.sv
// Directed bench for putc_uart_tx with CLKS_PER_BIT=4, DEPTH=16.
// Define PUTC_UART_TX_CRLF_EN for both files to exercise the CR/LF build.
module tb_putc_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef PUTC_UART_TX_CRLF_EN
    localparam int NF = 2;
`else
    localparam int NF = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          putc = 1'b0;
    logic [7:0]    putc_char = 8'h00;
    logic          full;
    logic [LW-1:0] level;
    logic          overflow;
    logic          busy;
    logic          tx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [8:0] rx_q[$];
    int         rx_t[$];
    logic [9:0] exp10;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    putc_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .putc(putc), .putc_char(putc_char),
        .full(full), .level(level), .overflow(overflow), .busy(busy), .tx(tx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] c);
        putc = 1'b1;
        putc_char = c;
        @(negedge clk);
        putc = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, rx_q.size(), n);
    endtask

    // Independent line decoder: samples mid-bit, stores {stop, data}.
    initial begin : rx_mon
        logic [8:0] f;
        int t0;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                t0 = cyc;
                repeat (2) @(negedge clk);
                for (int j = 0; j < 9; j++) begin
                    repeat (4) @(negedge clk);
                    f[j] = tx;
                end
                rx_q.push_back(f);
                rx_t.push_back(t0);
            end
        end
    end

    initial begin
        tick(2);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick(2);
        check("idle_tx", 32'(tx), 32'd1);

        // single 0x41 frame, cycle-exact
        send(8'h41);
        check("t1_lvl_k", 32'(level), 32'd1);
        check("t1_tx_k", 32'(tx), 32'd1);
        check("t1_busy_k", 32'(busy), 32'd1);
        exp10 = 10'b1010000010;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) check("t1_lvl_pop", 32'(level), 32'd0);
            check("t1_bit", 32'(exp10[i/4]), 32'(tx));
        end
        check("t1_busy_end", 32'(busy), 32'd1);
        tick(1);
        check("t1_busy_fall", 32'(busy), 32'd0);
        check("t1_tx_idle", 32'(tx), 32'd1);
        wait_frames(1, 10, "t1_nframes");
        check("t1_frame", 32'(rx_q[0]), 32'h141);
        rx_q.delete();
        rx_t.delete();

        // two back-to-back characters
        putc = 1'b1;
        putc_char = 8'h55;
        @(negedge clk);
        check("t2_lvl_a", 32'(level), 32'd1);
        putc_char = 8'hAA;
        @(negedge clk);
        putc = 1'b0;
        check("t2_lvl_b", 32'(level), 32'd1);
        check("t2_tx_start", 32'(tx), 32'd0);
        wait_frames(2, 200, "t2_nframes");
        check("t2_frame0", 32'(rx_q[0]), 32'h155);
        check("t2_frame1", 32'(rx_q[1]), 32'h1AA);
        check("t2_gap", 32'(rx_t[1] - rx_t[0]), 32'd40);
        check("t2_lvl_end", 32'(level), 32'd0);
        tick(5);
        check("t2_busy_end", 32'(busy), 32'd0);
        rx_q.delete();
        rx_t.delete();

        // fill to full, push+pop while full, then a dropped char
        for (int i = 0; i < 17; i++) begin
            putc = 1'b1;
            putc_char = 8'h10 + 8'(i);
            @(negedge clk);
        end
        putc = 1'b0;
        check("t3_lvl_full", 32'(level), 32'd16);
        check("t3_full", 32'(full), 32'd1);
        check("t3_ovf_pre", 32'(overflow), 32'd0);
        tick(24);
        putc = 1'b1;
        putc_char = 8'h21;
        @(negedge clk);
        check("t3_pp_lvl", 32'(level), 32'd16);
        check("t3_pp_full", 32'(full), 32'd1);
        check("t3_pp_ovf", 32'(overflow), 32'd0);
        putc_char = 8'h22;
        @(negedge clk);
        putc = 1'b0;
        check("t3_drop_ovf", 32'(overflow), 32'd1);
        check("t3_drop_lvl", 32'(level), 32'd16);
        wait_frames(18, 900, "t3_nframes");
        for (int i = 0; i < 18; i++)
            check("t3_frame", 32'(rx_q[i]), 32'({1'b1, 8'h10 + 8'(i)}));
        check("t3_span", 32'(rx_t[17] - rx_t[0]), 32'd680);
        tick(5);
        check("t3_busy_end", 32'(busy), 32'd0);
        check("t3_full_end", 32'(full), 32'd0);
        check("t3_ovf_sticky", 32'(overflow), 32'd1);
        rx_q.delete();
        rx_t.delete();

        // reset mid-DATA with three entries queued
        rst_n = 1'b0;
        tick(1);
        check("t4_ovf_clr", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick(1);
        putc = 1'b1;
        putc_char = 8'h41;
        @(negedge clk);
        putc_char = 8'h61;
        @(negedge clk);
        putc_char = 8'h62;
        @(negedge clk);
        putc_char = 8'h63;
        @(negedge clk);
        putc = 1'b0;
        check("t4_lvl", 32'(level), 32'd3);
        tick(10);
        rst_n = 1'b0;
        #1;
        check("t4_rst_tx", 32'(tx), 32'd1);
        check("t4_rst_lvl", 32'(level), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_full", 32'(full), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(60);
        rx_q.delete();
        rx_t.delete();
        tick(100);
        check("t4_noframe", rx_q.size(), 32'd0);
        check("t4_tx_idle", 32'(tx), 32'd1);
        check("t4_busy_idle", 32'(busy), 32'd0);

        // line feed: CR+LF pair or plain LF depending on build
        send(8'h0A);
        for (int i = 0; i < 40 * NF; i++) begin
            @(negedge clk);
            check("t5_busy", 32'(busy), 32'd1);
        end
        tick(1);
        check("t5_busy_fall", 32'(busy), 32'd0);
        wait_frames(NF, 10, "t5_nframes");
`ifdef PUTC_UART_TX_CRLF_EN
        check("t5_cr", 32'(rx_q[0]), 32'h10D);
        check("t5_lf", 32'(rx_q[1]), 32'h10A);
        check("t5_gap", 32'(rx_t[1] - rx_t[0]), 32'd40);
`else
        check("t5_lf", 32'(rx_q[0]), 32'h10A);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
